instr_byte_serializer: RTL

- Writer side of the 8-bit instruction-load bus.
- Accepts a 16-bit instruction word over a valid/ready handshake and emits it as two byte transfers on the byte bus (O, Write, LH).
- LH=0 marks the LSB transfer, LH=1 the MSB transfer; this directly drives the instruction register's byte-load inputs.
- Sits between the fetch/program source and the instruction register; honours downstream Stall.

---
 rtl/instr_bus_pkg.sv | 16 +
 rtl/ser_hold_buf.sv | 47 ++++
 rtl/instr_byte_serializer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_bus_pkg.sv
// Shared types and constants for the 8-bit instruction-load byte bus.
package instr_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } ser_state_e;

   localparam logic LH_LSB = 1'b0;
   localparam logic LH_MSB = 1'b1;

   localparam int unsigned BYTE_W_DEF = 8;
   localparam int unsigned WORD_W_DEF = 16;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding buffer for the byte serializer.
// Only present when INSTR_SER_BUF_EN is defined.
`ifdef INSTR_SER_BUF_EN
module ser_hold_buf
   import instr_bus_pkg::*;
#(
   parameter int unsigned W = WORD_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] push_data_i,
   input  logic         push_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // A push on the same edge as a pop refills the entry.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (push_i) begin
         data_d  = push_data_i;
         valid_d = 1'b1;
      end else if (pop_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule
`endif

// File: rtl/instr_byte_serializer.sv
// Writer side of the instruction-load bus: one 16-bit word out as two bytes.
// INSTR_SER_BUF_EN adds a one-entry input buffer for back-to-back words.
module instr_byte_serializer
   import instr_bus_pkg::*;
#(
   parameter int unsigned BYTE_W    = BYTE_W_DEF,
   parameter int unsigned WORD_W    = WORD_W_DEF,
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned COUNT_W   = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [WORD_W-1:0]  InData,
   input  logic               InValid,
   output logic               InReady,
   input  logic               Stall,
   output logic [BYTE_W-1:0]  O,
   output logic               Write,
   output logic               LH,
   output logic               Busy,
   output logic               Done,
   output logic [COUNT_W-1:0] WordCount
);

   ser_state_e         state_q, state_d;
   logic [WORD_W-1:0]  hold_q, hold_d;
   logic               done_q, done_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic               accept;
   logic               second_xfer;
   logic               buf_valid;
   logic [WORD_W-1:0]  buf_data;
   logic               first_lh;

   assign accept      = InValid && InReady;
   assign second_xfer = (state_q == SECOND) && !Stall;
   assign first_lh    = MSB_FIRST ? LH_MSB : LH_LSB;

`ifdef INSTR_SER_BUF_EN
   logic buf_push;
   logic buf_pop;

   // A word arriving on the last-byte edge with the buffer empty goes
   // straight into Hold, so the buffer never holds data while IDLE.
   assign buf_push = accept && (state_q != IDLE) && !(second_xfer && !buf_valid);
   assign buf_pop  = second_xfer && buf_valid;
   assign InReady  = Reset && !buf_valid;

   ser_hold_buf #(.W(WORD_W)) u_buf (
      .clk_i       (Clock),
      .rst_ni      (Reset),
      .push_data_i (InData),
      .push_i      (buf_push),
      .pop_i       (buf_pop),
      .data_o      (buf_data),
      .valid_o     (buf_valid)
   );
`else
   assign InReady   = Reset && (state_q == IDLE);
   assign buf_valid = 1'b0;
   assign buf_data  = '0;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               hold_d  = InData;
               state_d = FIRST;
            end
         end
         FIRST: begin
            if (!Stall) state_d = SECOND;
         end
         SECOND: begin
            if (!Stall) begin
               done_d  = 1'b1;
               count_d = count_q + COUNT_W'(1);
               if (buf_valid) begin
                  hold_d  = buf_data;
                  state_d = FIRST;
               end else if (accept) begin
                  hold_d  = InData;
                  state_d = FIRST;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   // Bus outputs depend only on state and Hold.
   always_comb begin
      Write = 1'b0;
      LH    = LH_LSB;
      O     = '0;
      unique case (state_q)
         FIRST: begin
            Write = 1'b1;
            LH    = first_lh;
         end
         SECOND: begin
            Write = 1'b1;
            LH    = ~first_lh;
         end
         default: ;
      endcase
      if (Write) O = LH ? hold_q[WORD_W-1 -: BYTE_W] : hold_q[BYTE_W-1:0];
   end

   assign Busy      = (state_q != IDLE);
   assign Done      = done_q;
   assign WordCount = count_q;

endmodule
